// File: rtl/clock_pkg.sv
// Shared constants and FSM state encoding for the master clock chain.
package clock_pkg;

    localparam int CLK_DIV_W  = 4;
    localparam int CLK_PHASES = 3;
    localparam int CLK_PH_W   = 2;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_PAUSED,
        ST_STEP
    } run_state_t;

endpackage

// File: rtl/clk_prescale.sv
// CLK_DRV prescaler: counts 0..div, strobes on terminal count, holds while paused.
// The divide value is latched on reload (period boundary) and on the first cycle after reset.
module clk_prescale #(
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             hold_i,
    input  logic             reload_i,
    output logic             strobe_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_eff;
    logic             init_q;

    // Until the first clock after reset the latch is empty, so use DIV directly.
    assign div_eff  = init_q ? div_i : div_q;
    assign strobe_o = !rst_i && !hold_i && (cnt_q == div_eff);

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (!hold_i)
            cnt_d = strobe_o ? '0 : cnt_q + 1'b1;
        if (init_q || reload_i)
            div_d = div_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= '0;
            init_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            init_q <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_run_ctrl.sv
// Run/pause/single-step sequencer for the master clock chain; stops only on period boundaries.
// Define CLK_STEP_EN to build the single-step path (STEP state, STEP_REQ edge detect, STEP_ACK).
module clock_run_ctrl
    import clock_pkg::*;
#(
    parameter int DIV_W  = CLK_DIV_W,
    parameter int PHASES = CLK_PHASES,
    parameter int PH_W   = CLK_PH_W
) (
    input  logic             CLK_DRV,
    input  logic             RESET,
    input  logic [DIV_W-1:0] DIV,
    input  logic             PAUSE_REQ,
    input  logic             STEP_REQ,
    output logic             CLK_SRC_EN,
    output logic [PH_W-1:0]  PHASE,
    output logic             PERIOD_END,
    output logic             PAUSED,
    output logic             STEP_ACK
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    run_state_t      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            strobe;
    logic            period_end;
    logic            hold;

    assign hold       = (state_q == ST_PAUSED);
    assign period_end = strobe && (phase_q == PH_LAST);

    clk_prescale #(.DIV_W(DIV_W)) u_prescale (
        .clk_i    (CLK_DRV),
        .rst_i    (RESET),
        .div_i    (DIV),
        .hold_i   (hold),
        .reload_i (period_end),
        .strobe_o (strobe)
    );

`ifdef CLK_STEP_EN
    logic step_q;
    logic step_rise;
    logic ack_q, ack_d;

    assign step_rise = STEP_REQ && !step_q;
    assign STEP_ACK  = ack_q;

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            step_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            step_q <= STEP_REQ;
            ack_q  <= ack_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = STEP_REQ;
    assign STEP_ACK    = 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        if (strobe)
            phase_d = period_end ? '0 : phase_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
`ifdef CLK_STEP_EN
        ack_d   = 1'b0;
`endif
        case (state_q)
            ST_RUN:
                if (PAUSE_REQ) state_d = ST_DRAIN;
            // A dropped request beats a coincident period end: keep running.
            ST_DRAIN:
                if (!PAUSE_REQ)      state_d = ST_RUN;
                else if (period_end) state_d = ST_PAUSED;
            ST_PAUSED:
                if (!PAUSE_REQ) state_d = ST_RUN;
`ifdef CLK_STEP_EN
                else if (step_rise) state_d = ST_STEP;
            ST_STEP:
                if (period_end) begin
                    state_d = ST_PAUSED;
                    ack_d   = 1'b1;
                end
`endif
            default:
                state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    assign CLK_SRC_EN = strobe;
    assign PHASE      = phase_q;
    assign PERIOD_END = period_end;
    assign PAUSED     = (state_q == ST_PAUSED);

endmodule
